// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared types and constants for the period meter
package period_meter_pkg;

  localparam int PM_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } pm_state_t;

  // Result record at the default counter width.
  typedef struct packed {
    logic [PM_CNT_W-1:0] period;
    logic [PM_CNT_W-1:0] high_time;
    logic                overrun;
  } pm_result_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-stage synchronizer with rising-edge detector
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl  = sync_q[STAGES-1];
  assign rise = lvl & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - period and high-time meter for a slow asynchronous square wave
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = PM_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic             lvl;
  logic             rise;
  pm_state_t        state_q;
  pm_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic             load;
  logic             capture;
  logic             count;

  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (f_in),
    .lvl (lvl),
    .rise(rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Saturation is decided one step ahead so timeout rises together with cnt hitting the limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = MEASURE;
      MEASURE: if (!rise && cnt_q == CNT_SAT - CNT_W'(1)) state_d = TIMEOUT;
      TIMEOUT: if (rise) state_d = MEASURE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    capture = 1'b0;
    count   = 1'b0;
    case (state_q)
      IDLE, TIMEOUT: load = rise;
      MEASURE: begin
        load    = rise;
        capture = rise;
        count   = !rise;
      end
      default: ;
    endcase
  end

  // The edge cycle itself is high, hence the reload to 1 for both counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      hcnt_q <= '0;
    end else if (load) begin
      cnt_q  <= CNT_W'(1);
      hcnt_q <= CNT_W'(1);
    end else if (count) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (lvl) hcnt_q <= hcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= (state_d == TIMEOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid   <= 1'b0;
      period    <= '0;
      high_time <= '0;
      overrun   <= 1'b0;
    end else if (capture) begin
      period    <= cnt_q;
      high_time <= hcnt_q;
      overrun   <= m_valid & ~m_ready;
      m_valid   <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - randomized self-checking bench for period_meter
module tb_period_meter;
  import period_meter_pkg::*;

  localparam int LAT = 3;

  typedef struct packed {
    logic        v;
    logic [15:0] p;
    logic [15:0] h;
    logic        o;
    logic        t;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        f_in;
  logic        m_ready;
  logic        m_valid;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        overrun;
  logic        timeout;
  logic        m_valid4;
  logic [3:0]  period4;
  logic [3:0]  high_time4;
  logic        overrun4;
  logic        timeout4;

  int total;
  int bad;

  bit         fv[$];
  bit         rv[$];
  obs_t       ob[$];
  obs_t       ob4[$];
  pm_result_t exp_q[$];
  pm_result_t got_q[$];

  period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .f_in(f_in), .m_valid(m_valid), .m_ready(m_ready),
    .period(period), .high_time(high_time), .overrun(overrun), .timeout(timeout)
  );

  period_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .f_in(f_in), .m_valid(m_valid4), .m_ready(m_ready),
    .period(period4), .high_time(high_time4), .overrun(overrun4), .timeout(timeout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add_seg(input bit val, input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      fv.push_back(val);
      rv.push_back(r);
    end
  endfunction

  // Each pair of consecutive rising edges of the stimulus is one result.
  function automatic void wave_model();
    int last;
    int hi;
    last = -1;
    hi   = 0;
    exp_q.delete();
    for (int s = 0; s < fv.size(); s++) begin
      if (fv[s] && (s == 0 || !fv[s-1])) begin
        if (last >= 0) exp_q.push_back('{period: 16'(s - last), high_time: 16'(hi), overrun: 1'b0});
        last = s;
        hi   = 0;
      end
      if (fv[s]) hi++;
    end
  endfunction

  function automatic void collect(input bit use4);
    obs_t o;
    got_q.delete();
    for (int s = 0; s < rv.size(); s++) begin
      o = use4 ? ob4[s] : ob[s];
      if (o.v && rv[s]) got_q.push_back('{period: o.p, high_time: o.h, overrun: o.o});
    end
  endfunction

  task automatic play();
    ob.delete();
    ob4.delete();
    for (int s = 0; s < fv.size(); s++) begin
      @(negedge clk);
      f_in    = fv[s];
      m_ready = rv[s];
      #2;
      ob.push_back('{v: m_valid, p: period, h: high_time, o: overrun, t: timeout});
      ob4.push_back('{v: m_valid4, p: 16'(period4), h: 16'(high_time4), o: overrun4, t: timeout4});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    f_in    = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fv.delete();
    rv.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      f_in = ~f_in;
      #2;
      total++;
      if ({m_valid, period, high_time, overrun, timeout, m_valid4, period4, high_time4, overrun4, timeout4} !== '0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got v=%0d p=%0d h=%0d o=%0d t=%0d v4=%0d t4=%0d want all 0",
                 i, m_valid, period, high_time, overrun, timeout, m_valid4, timeout4);
      end
    end
    @(negedge clk);
    rst  = 1'b0;
    f_in = 1'b0;
  endtask

  task automatic test_steady();
    int first;
    do_reset();
    add_seg(0, 3, 1);
    repeat (5) begin
      add_seg(1, 3, 1);
      add_seg(0, 5, 1);
    end
    add_seg(1, 1, 1);
    add_seg(0, 6, 1);
    wave_model();
    play();
    collect(0);
    total++;
    if (got_q.size() != 5) begin
      bad++;
      $display("FAIL steady_count: got %0d want 5", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i] || got_q[i].period !== 16'd8 || got_q[i].high_time !== 16'd3) begin
        bad++;
        $display("FAIL steady_result[%0d]: got p=%0d h=%0d o=%0d want p=8 h=3 o=0",
                 i, got_q[i].period, got_q[i].high_time, got_q[i].overrun);
      end
    end
    first = -1;
    for (int s = 0; s < ob.size(); s++)
      if (ob[s].v && first < 0) first = s;
    total++;
    if (first != 3 + 8 + LAT) begin
      bad++;
      $display("FAIL steady_first_valid: got slot %0d want %0d", first, 3 + 8 + LAT);
    end
  endtask

  task automatic test_fastest();
    do_reset();
    add_seg(0, 3, 1);
    repeat (6) begin
      add_seg(1, 1, 1);
      add_seg(0, 1, 1);
    end
    add_seg(1, 1, 1);
    add_seg(0, 6, 1);
    wave_model();
    play();
    collect(0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL fast_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL fast_result[%0d]: got p=%0d h=%0d o=%0d want p=%0d h=%0d o=0",
                 i, got_q[i].period, got_q[i].high_time, got_q[i].overrun,
                 exp_q[i].period, exp_q[i].high_time);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    add_seg(0, 3, 1);
    repeat (10) begin
      add_seg(1, $urandom_range(1, 6), 1);
      add_seg(0, $urandom_range(1, 6), 1);
    end
    add_seg(1, 1, 1);
    add_seg(0, 6, 1);
    wave_model();
    play();
    collect(0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random_result[%0d]: got p=%0d h=%0d o=%0d want p=%0d h=%0d o=0",
                 i, got_q[i].period, got_q[i].high_time, got_q[i].overrun,
                 exp_q[i].period, exp_q[i].high_time);
      end
    end
  endtask

  task automatic test_backpressure();
    int hb, lb, hc, lc, e1, e2, e3;
    do_reset();
    hb = $urandom_range(1, 3);
    lb = $urandom_range(2, 5);
    hc = $urandom_range(1, 3);
    lc = $urandom_range(2, 5);
    add_seg(0, 3, 0);
    add_seg(1, 2, 0);
    add_seg(0, 4, 0);
    add_seg(1, hb, 0);
    add_seg(0, lb, 0);
    add_seg(1, hc, 0);
    add_seg(0, lc, 0);
    add_seg(1, 1, 0);
    add_seg(0, 8, 0);
    e1 = 3 + 6;
    e2 = e1 + hb + lb;
    e3 = e2 + hc + lc;
    for (int s = e3 + 2; s < rv.size(); s++) rv[s] = 1'b1;
    play();
    total++;
    if (ob[e1+LAT].v !== 1'b1 || ob[e1+LAT].p !== 16'd6 || ob[e1+LAT].h !== 16'd2 || ob[e1+LAT].o !== 1'b0) begin
      bad++;
      $display("FAIL bp_first: got v=%0d p=%0d h=%0d o=%0d want v=1 p=6 h=2 o=0",
               ob[e1+LAT].v, ob[e1+LAT].p, ob[e1+LAT].h, ob[e1+LAT].o);
    end
    total++;
    if (ob[e2+LAT].v !== 1'b1 || ob[e2+LAT].p !== 16'(hb + lb) || ob[e2+LAT].h !== 16'(hb) || ob[e2+LAT].o !== 1'b1) begin
      bad++;
      $display("FAIL bp_overrun: got v=%0d p=%0d h=%0d o=%0d want v=1 p=%0d h=%0d o=1",
               ob[e2+LAT].v, ob[e2+LAT].p, ob[e2+LAT].h, ob[e2+LAT].o, hb + lb, hb);
    end
    total++;
    if (ob[e3+LAT].v !== 1'b1 || ob[e3+LAT].p !== 16'(hc + lc) || ob[e3+LAT].h !== 16'(hc) || ob[e3+LAT].o !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept_on_capture: got v=%0d p=%0d h=%0d o=%0d want v=1 p=%0d h=%0d o=0",
               ob[e3+LAT].v, ob[e3+LAT].p, ob[e3+LAT].h, ob[e3+LAT].o, hc + lc, hc);
    end
    total++;
    if (ob[e3+LAT+1].v !== 1'b0) begin
      bad++;
      $display("FAIL bp_drained: got v=%0d want v=0", ob[e3+LAT+1].v);
    end
    collect(0);
    total++;
    if (got_q.size() != 2 ||
        got_q[0] !== pm_result_t'{period: 16'(hb + lb), high_time: 16'(hb), overrun: 1'b1} ||
        got_q[1] !== pm_result_t'{period: 16'(hc + lc), high_time: 16'(hc), overrun: 1'b0}) begin
      bad++;
      $display("FAIL bp_accepted: got %0d results want 2 (p=%0d o=1, p=%0d o=0)",
               got_q.size(), hb + lb, hc + lc);
    end
  endtask

  task automatic test_timeout();
    int e1, t_on;
    do_reset();
    add_seg(0, 3, 1);
    add_seg(1, 1, 1);
    add_seg(0, 20, 1);
    add_seg(1, 2, 1);
    add_seg(0, 4, 1);
    add_seg(1, 1, 1);
    add_seg(0, 6, 1);
    e1   = 24;
    t_on = 3 + LAT + 14;
    play();
    total++;
    if (ob4[t_on-1].t !== 1'b0 || ob4[t_on].t !== 1'b1) begin
      bad++;
      $display("FAIL timeout_assert: got t[%0d]=%0d t[%0d]=%0d want 0 then 1",
               t_on - 1, ob4[t_on-1].t, t_on, ob4[t_on].t);
    end
    total++;
    if (ob4[e1+LAT-1].t !== 1'b1 || ob4[e1+LAT].t !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got t[%0d]=%0d t[%0d]=%0d want 1 then 0",
               e1 + LAT - 1, ob4[e1+LAT-1].t, e1 + LAT, ob4[e1+LAT].t);
    end
    collect(1);
    total++;
    if (got_q.size() != 1 || got_q[0] !== pm_result_t'{period: 16'd6, high_time: 16'd2, overrun: 1'b0}) begin
      bad++;
      $display("FAIL timeout_result: got %0d results (first p=%0d) want 1 result p=6 h=2",
               got_q.size(), (got_q.size() > 0) ? got_q[0].period : 16'd0);
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    do_reset();
    add_seg(0, 3, 0);
    add_seg(1, 2, 0);
    add_seg(0, 4, 0);
    add_seg(1, 2, 0);
    add_seg(0, 4, 0);
    add_seg(1, 1, 0);
    add_seg(0, 3, 0);
    play();
    total++;
    if (ob[ob.size()-1].v !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre_valid: got v=%0d want 1", ob[ob.size()-1].v);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({m_valid, period, high_time, overrun, timeout, m_valid4, period4, high_time4, overrun4, timeout4} !== '0) begin
      bad++;
      $display("FAIL midrst_clear: got v=%0d p=%0d h=%0d o=%0d t=%0d want all 0",
               m_valid, period, high_time, overrun, timeout);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fv.delete();
    rv.delete();
    add_seg(0, 2, 1);
    add_seg(1, 2, 1);
    add_seg(0, 12, 1);
    play();
    nv = 0;
    for (int s = 0; s < ob.size(); s++) nv += int'(ob[s].v) + int'(ob4[s].v);
    total++;
    if (nv != 0) begin
      bad++;
      $display("FAIL midrst_first_edge: got %0d valid slots want 0", nv);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    f_in    = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_steady();
    test_fastest();
    test_random();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
